// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg : configurable UART receiver with status-carrying RX FIFO.
//
// The serial input is synchronised, framed by a bit-timer driven FSM,
// and each received character is written into a first-word-fall-through
// FIFO together with its parity, framing and break status.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   rx_pin_i            asynchronous serial input, idle high
//   rx_en_i             receiver enable (checked only when a frame starts)
//   baud_div_i          clk cycles per bit (>= 4)
//   data_bits_i         00=5, 01=6, 10=7, 11=8 data bits
//   parity_en_i         parity bit present
//   parity_odd_i        1 = odd parity, 0 = even parity
//   stop2_i             1 = two stop bits
//   rx_fifo_read_i      pop the head entry
//   rx_fifo_data_o      head character, right-justified
//   rx_parity_err_o     head entry parity error
//   rx_frame_err_o      head entry framing error
//   rx_break_o          head entry is a break
//   rx_fifo_empty_o     FIFO empty
//   rx_fifo_full_o      FIFO full
//   rx_fifo_count_o     FIFO occupancy, 0..DEPTH
//   rx_watermark_i      occupancy threshold
//   rx_fifo_mark_o      registered (count >= watermark)
//   overrun_o           sticky overrun, cleared by err_clr_i
//   err_clr_i           clears overrun_o (a same-cycle set wins)
//   rx_busy_o           receiver FSM not idle
//   dbg_state_o         current FSM state encoding
//
// FIFO handshake: the head entry is valid whenever rx_fifo_empty_o is 0;
// a pop happens on a clock edge where rx_fifo_read_i=1 and the FIFO is not
// empty. A read while empty is ignored. The receive side has no
// back-pressure: a push into a full FIFO with no pop that cycle is dropped
// and raises overrun_o.
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
   parameter int DEPTH  = 8,
   parameter int BAUD_W = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_pin_i,
   input  logic              rx_en_i,
   input  logic [BAUD_W-1:0] baud_div_i,
   input  logic [1:0]        data_bits_i,
   input  logic              parity_en_i,
   input  logic              parity_odd_i,
   input  logic              stop2_i,
   input  logic              rx_fifo_read_i,
   output logic [7:0]        rx_fifo_data_o,
   output logic              rx_parity_err_o,
   output logic              rx_frame_err_o,
   output logic              rx_break_o,
   output logic              rx_fifo_empty_o,
   output logic              rx_fifo_full_o,
   output logic [CW-1:0]     rx_fifo_count_o,
   input  logic [CW-1:0]     rx_watermark_i,
   output logic              rx_fifo_mark_o,
   output logic              overrun_o,
   input  logic              err_clr_i,
   output logic              rx_busy_o,
   output logic [2:0]        dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_START      = 3'd1,
      S_DATA       = 3'd2,
      S_PARITY     = 3'd3,
      S_STOP       = 3'd4,
      S_BREAK_WAIT = 3'd5
   } state_t;

   state_t state_q, state_d;

   // ---------------- synchroniser ----------------
   logic sync1_q, sync2_q;
   logic rxs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_pin_i;
         sync2_q <= sync1_q;
      end
   end

   assign rxs = sync2_q;

   // ---------------- frame datapath registers ----------------
   logic [BAUD_W-1:0] cnt_q;
   logic [1:0]        len_q;
   logic              pen_q, podd_q, stop2_q;
   logic [7:0]        shift_q;
   logic [2:0]        bit_cnt_q;
   logic              par_bit_q;
   logic              stop_cnt_q;
   logic              stop0_q;
   logic              frame_err_q;
   logic              push_q;
   logic [10:0]       entry_q;

   logic smp_mid, smp_end;
   logic last_data;
   logic first_stop;
   logic frame_brk;

   assign smp_mid   = (cnt_q == (baud_div_i >> 1));
   assign smp_end   = (cnt_q == (baud_div_i - 1'b1));
   assign last_data = (bit_cnt_q == ({1'b0, len_q} + 3'd4));
   // First stop bit: live sample while taking it, stored value afterwards.
   assign first_stop = stop_cnt_q ? stop0_q : rxs;
   assign frame_brk  = (shift_q == 8'h00) && !(pen_q && par_bit_q) && !first_stop;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (rx_en_i && !rxs) state_d = S_START;
         end
         S_START: begin
            if (smp_mid) state_d = rxs ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (smp_end && last_data) state_d = pen_q ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (smp_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (smp_end && (!stop2_q || stop_cnt_q))
               state_d = frame_brk ? S_BREAK_WAIT : S_IDLE;
         end
         S_BREAK_WAIT: begin
            if (rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs / datapath controls ----------------
   logic load_cfg, cnt_clr, shift_en, par_smp, stop_smp, stop_last;

   always_comb begin
      load_cfg  = 1'b0;
      cnt_clr   = 1'b0;
      shift_en  = 1'b0;
      par_smp   = 1'b0;
      stop_smp  = 1'b0;
      stop_last = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_clr  = 1'b1;
            load_cfg = rx_en_i && !rxs;
         end
         S_START: cnt_clr = smp_mid;
         S_DATA: begin
            cnt_clr  = smp_end;
            shift_en = smp_end;
         end
         S_PARITY: begin
            cnt_clr = smp_end;
            par_smp = smp_end;
         end
         S_STOP: begin
            cnt_clr   = smp_end;
            stop_smp  = smp_end;
            stop_last = smp_end && (!stop2_q || stop_cnt_q);
         end
         S_BREAK_WAIT: cnt_clr = 1'b1;
         default: cnt_clr = 1'b1;
      endcase
   end

   assign rx_busy_o   = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

   // Character as it will be stored: shifted in at bit 7, so shorter
   // characters need moving down by (8 - length).
   logic [1:0] rj_sh;
   logic [7:0] char_rj;
   logic       perr_calc;
   logic       ferr_calc;

   assign rj_sh     = 2'd3 - len_q;
   assign char_rj   = shift_q >> rj_sh;
   assign perr_calc = pen_q && ((^shift_q) ^ par_bit_q ^ podd_q);
   assign ferr_calc = frame_err_q || !rxs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         len_q       <= 2'd0;
         pen_q       <= 1'b0;
         podd_q      <= 1'b0;
         stop2_q     <= 1'b0;
         shift_q     <= 8'h00;
         bit_cnt_q   <= 3'd0;
         par_bit_q   <= 1'b0;
         stop_cnt_q  <= 1'b0;
         stop0_q     <= 1'b1;
         frame_err_q <= 1'b0;
         push_q      <= 1'b0;
         entry_q     <= 11'h000;
      end else begin
         cnt_q  <= cnt_clr ? '0 : cnt_q + 1'b1;
         push_q <= stop_last;
         if (load_cfg) begin
            len_q       <= data_bits_i;
            pen_q       <= parity_en_i;
            podd_q      <= parity_odd_i;
            stop2_q     <= stop2_i;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            par_bit_q   <= 1'b0;
            stop_cnt_q  <= 1'b0;
            stop0_q     <= 1'b1;
            frame_err_q <= 1'b0;
         end
         if (shift_en) begin
            shift_q   <= {rxs, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
         end
         if (par_smp) par_bit_q <= rxs;
         if (stop_smp) begin
            stop_cnt_q  <= 1'b1;
            frame_err_q <= ferr_calc;
            if (!stop_cnt_q) stop0_q <= rxs;
         end
         if (stop_last) begin
            // Entry layout: {break, frame_err, parity_err, data[7:0]}
            entry_q <= {frame_brk, ferr_calc, perr_calc, frame_brk ? 8'h00 : char_rj};
         end
      end
   end

   // ---------------- RX FIFO ----------------
   logic [10:0]   mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;
   logic          mark_q, overrun_q;
   logic          empty, full, pop, push_ok, ovr_set;
   logic [10:0]   head;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign pop     = rx_fifo_read_i && !empty;
   // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
   assign push_ok = push_q && (!full || pop);
   assign ovr_set = push_q && full && !pop;
   assign head    = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= entry_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         mark_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop)     rptr_q <= rptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         mark_q <= (count_q >= rx_watermark_i);
         if (ovr_set)        overrun_q <= 1'b1;
         else if (err_clr_i) overrun_q <= 1'b0;
      end
   end

   assign rx_fifo_empty_o = empty;
   assign rx_fifo_full_o  = full;
   assign rx_fifo_count_o = count_q;
   assign rx_fifo_mark_o  = mark_q;
   assign overrun_o       = overrun_q;
   assign rx_fifo_data_o  = empty ? 8'h00 : head[7:0];
   assign rx_parity_err_o = !empty && head[8];
   assign rx_frame_err_o  = !empty && head[9];
   assign rx_break_o      = !empty && head[10];

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Configurable UART receiver, next generation of the single-mode RX path in the UART peripheral.
- Adds runtime-selectable data length (5–8 bits), parity (none/even/odd) and stop bits (1/2).
- Adds false-start rejection, per-character parity/framing/break status, and sticky overrun.
- Stores characters plus status in a parametrised first-word-fall-through FIFO read by the UART register block.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, ≥2.
- BAUD_W, 16, width of the baud divisor.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_pin_i  in  1  serial input; asynchronous, idle high.
- rx_en_i  in  1  receiver enable.
- baud_div_i  in  BAUD_W  clk cycles per bit; valid range ≥4.
- data_bits_i  in  2  character length: 00=5, 01=6, 10=7, 11=8 bits.
- parity_en_i  in  1  parity bit present.
- parity_odd_i  in  1  1=odd parity, 0=even parity.
- stop2_i  in  1  1 = two stop bits.
- rx_fifo_read_i  in  1  pop head entry.
- rx_fifo_data_o  out  8  head character, right-justified, unused MSBs 0.
- rx_parity_err_o  out  1  head entry parity error.
- rx_frame_err_o  out  1  head entry framing error.
- rx_break_o  out  1  head entry is a break.
- rx_fifo_empty_o  out  1  FIFO empty.
- rx_fifo_full_o  out  1  FIFO full.
- rx_fifo_count_o  out  $clog2(DEPTH)+1  occupancy.
- rx_watermark_i  in  $clog2(DEPTH)+1  threshold.
- rx_fifo_mark_o  out  1  registered flag, (count ≥ watermark).
- overrun_o  out  1  sticky overrun.
- err_clr_i  in  1  clears overrun_o.
- rx_busy_o  out  1  state ≠ IDLE.

Behaviour:
- Reset values: empty=1, full=0, count=0, data/status outputs 0, mark=0, overrun=0, busy=0; FSM in IDLE; synchroniser flops = 1.
- Input path: rx_pin_i passes through a 2-flop synchroniser to produce rxs. All sampling uses rxs.
- Bit timer: cnt (BAUD_W bits) counts up from 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE:
  - Enter START when rx_en_i=1 and rxs=0; cnt cleared.
  - data_bits_i, parity_en_i, parity_odd_i and stop2_i are latched on this transition and held for the whole frame.
  - FIFO fullness does not block reception.
- START:
  - At cnt == baud_div_i>>1, sample rxs.
  - If rxs=1: false start, return to IDLE, nothing pushed.
  - If rxs=0: clear cnt, go to DATA.
- DATA:
  - At cnt == baud_div_i−1, sample rxs into the shifter (LSB first) and clear cnt.
  - After N samples (N = latched length), go to PARITY if parity is enabled, else STOP.
- PARITY: sample at cnt == baud_div_i−1. parity_err = XOR(data bits, parity bit, parity_odd).
- STOP:
  - Sample one or two stop bits, each at cnt == baud_div_i−1.
  - frame_err = 1 if any sampled stop bit is 0.
  - After the final stop sample: push one entry on the next clock. Push is unconditional, including when errors are set.
  - Then go to IDLE, or to BREAK_WAIT if break.
- Break detection: break = all data bits 0, parity bit 0 (if present), and first stop bit 0. A break entry carries data 0, break=1, frame_err=1.
- BREAK_WAIT: stay until rxs=1, then go to IDLE. No further entries are pushed while the line is held low.
- rx_en_i deasserted mid-frame: the current frame completes; the FSM then remains in IDLE.
- Changing baud_div_i mid-frame: undefined.
- FIFO:
  - Entry width is 11 bits (data + 3 status bits).
  - Head entry is visible combinationally whenever not empty.
  - Read when empty is ignored.
  - Push when full and no read in the same cycle: entry dropped, overrun_o set to 1.
  - Push and read in the same cycle when full: both succeed, count unchanged, no overrun.
  - Simultaneous push and read when empty: the push succeeds and the read is ignored.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- overrun_o: cleared by err_clr_i. If set and clear occur in the same cycle, set wins.
- rx_fifo_mark_o: updated one cycle after the count changes.
- Async reset mid-frame: FSM returns to IDLE, FIFO is emptied, all flags are cleared, and the partial character is discarded.

Test Plan:
- 8N1 framing: baud_div=16, 8N1; drive 0xA5 LSB-first with 16-cycle bits → one entry 0xA5, all errors 0. The push occurs 1 cycle after the stop sample, about 152 cycles after the start edge plus synchroniser delay.
- 7O2 parity error: baud_div=16; send 0x41 with wrong parity bit=0 → entry 0x41, parity_err=1, frame_err=0. Repeat with second stop bit low → frame_err=1.
- False start: line low for 5 cycles, baud_div=16 → FSM returns to IDLE, FIFO stays empty, busy drops.
- Overrun: DEPTH=4; receive 5 characters 0x01..0x05 without reading → count=4, overrun_o=1, FIFO holds 0x01..0x04. Pop 4 → 0x01..0x04 in order, empty=1. Pulse err_clr → overrun_o=0.
- Full with same-cycle read: with the FIFO full, assert rx_fifo_read_i in the cycle of the 5th push → no overrun, count stays 4, head advances.
- Break: hold the line low for 20 bit times (8N1) → exactly one entry: data 0x00, break=1, frame_err=1. Release high, then send 0x3C → next entry 0x3C, no errors.
- Watermark: watermark=3; push 3 characters → mark=1 one cycle after count=3. One pop → mark=0.
